// File: rtl/tmnt_io_frame.sv
// Pad frame for the TMNT user project: button synchronise/debounce/encode,
// registered core outputs with chip-select gated output enables.
module tmnt_io_frame #(
    parameter int N_PB      = 15,
    parameter int PB_BASE   = 0,
    parameter int OUT_BASE  = 15,
    parameter int MODE_W    = 2,
    parameter int DB_CYCLES = 16,
    localparam int IDX_W    = (N_PB > 1) ? $clog2(N_PB) : 1,
    localparam int CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ncs,
    input  logic [33:0]       gpio_in,
    output logic [33:0]       gpio_out,
    output logic [33:0]       gpio_oeb,
    input  logic              core_sigout,
    input  logic [MODE_W-1:0] core_mode,
    output logic [N_PB-1:0]   pb_clean,
    output logic [N_PB-1:0]   pb_press,
    output logic [IDX_W-1:0]  key_idx,
    output logic              key_valid
);

    localparam int OUT_W = 1 + MODE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    localparam bit LEGAL =
        (N_PB >= 1) && (N_PB <= 30) && (MODE_W >= 1) && (MODE_W <= 4) &&
        (DB_CYCLES >= 1) && (PB_BASE >= 0) && (OUT_BASE >= 0) &&
        (PB_BASE + N_PB <= 34) && (OUT_BASE + OUT_W <= 34) &&
        ((PB_BASE + N_PB <= OUT_BASE) || (OUT_BASE + OUT_W <= PB_BASE));

    generate
        if (!LEGAL) begin : g_illegal_map
            $error("tmnt_io_frame: illegal parameters or overlapping pin ranges");
        end
    endgenerate

    logic              ncs_m, ncs_s;
    logic [N_PB-1:0]   s1, s2;
    logic [CNT_W-1:0]  cnt [N_PB];
    logic [IDX_W-1:0]  idx_next;
    logic [OUT_W-1:0]  out_q;
    logic              unused_gpio;

    // Pins outside the button range are read elsewhere in the SoC, not here.
    assign unused_gpio = ^gpio_in;

    // NOTE: all state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse
    // the two-flop synchronisers into one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ncs_m <= 1'b1;
            ncs_s <= 1'b1;
            s1    <= '0;
            s2    <= '0;
        end else begin
            ncs_m <= ncs;
            ncs_s <= ncs_m;
            s1    <= gpio_in[PB_BASE +: N_PB];
            s2    <= s1;
        end
    end

    // NOTE: the small per-button counter array is reset like ordinary flops;
    // a stale count after reset would let a half-debounced edge slip through.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pb_clean <= '0;
            pb_press <= '0;
            for (int i = 0; i < N_PB; i++) cnt[i] <= '0;
        end else if (ncs_s) begin
            pb_clean <= '0;
            pb_press <= '0;
            for (int i = 0; i < N_PB; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PB; i++) begin
                pb_press[i] <= 1'b0;
                if (s2[i] == pb_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    pb_clean[i] <= s2[i];
                    pb_press[i] <= s2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: idx_next gets a default before the loop so no latch is inferred
    // when no button is held.
    always_comb begin
        idx_next = '0;
        for (int i = N_PB - 1; i >= 0; i--) begin
            if (pb_clean[i]) idx_next = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_idx   <= '0;
            key_valid <= 1'b0;
        end else if (ncs_s) begin
            key_idx   <= '0;
            key_valid <= 1'b0;
        end else begin
            key_idx   <= idx_next;
            key_valid <= |pb_clean;
        end
    end

    // Core outputs keep tracking while deselected; only the enables drop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) out_q <= '0;
        else        out_q <= {core_mode, core_sigout};
    end

    always_comb begin
        gpio_out                     = '0;
        gpio_out[OUT_BASE +: OUT_W]  = out_q;
        gpio_oeb                     = '1;
        gpio_oeb[OUT_BASE +: OUT_W]  = {OUT_W{ncs_s}};
    end

endmodule
